// File: rtl/dot_seq_pkg.sv
// rtl/dot_seq_pkg.sv - shared types and lane geometry for the dot-product sequencer and datapath
package dot_seq_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 32;
    localparam int VEC_W  = LANES * LANE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dot_lane_mask.sv
// rtl/dot_lane_mask.sv - zeroes lanes at or above the tail count on the final beat of a vector
module dot_lane_mask
    import dot_seq_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    input  logic [1:0]       tail,
    input  logic             last,
    output logic [VEC_W-1:0] masked
);

    // tail==0 means the last beat is full, so only a non-zero tail trims lanes
    always_comb begin
        masked = vec;
        for (int i = 0; i < LANES; i++) begin
            if (last && (tail != 2'd0) && (i >= int'(tail))) begin
                masked[i*LANE_W +: LANE_W] = '0;
            end
        end
    end

endmodule

// File: rtl/dot_seq_ctrl.sv
// rtl/dot_seq_ctrl.sv - command sequencer streaming masked operand beats and accumulating the dot product
module dot_seq_ctrl
    import dot_seq_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [VEC_W-1:0]  in_a,
    input  logic [VEC_W-1:0]  in_b,
    output logic [VEC_W-1:0]  dp_vec_a,
    output logic [VEC_W-1:0]  dp_vec_b,
    input  logic [LANE_W-1:0] dp_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [LANE_W-1:0] res_data,
    output logic              busy
);

    state_t             state;
    logic [LEN_W-1:0]   beats_left;
    logic [1:0]         tail;
    logic [LANE_W-1:0]  acc;
    logic               last_beat;
    logic [VEC_W-1:0]   masked_a;
    logic [VEC_W-1:0]   masked_b;

    assign last_beat = (beats_left == LEN_W'(1));

    // handshake flags decode straight from the registered state
    assign cmd_ready = (state == IDLE);
    assign in_ready  = (state == RUN);
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);

    dot_lane_mask u_mask_a (
        .vec    (in_a),
        .tail   (tail),
        .last   (last_beat),
        .masked (masked_a)
    );

    dot_lane_mask u_mask_b (
        .vec    (in_b),
        .tail   (tail),
        .last   (last_beat),
        .masked (masked_b)
    );

    // datapath sees operands only while beats are being consumed
    assign dp_vec_a = (state == RUN) ? masked_a : '0;
    assign dp_vec_b = (state == RUN) ? masked_b : '0;

    // sequencer FSM: accept command, count beats, accumulate, hold result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            beats_left <= '0;
            tail       <= '0;
            res_data   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_len == '0) begin
                            state    <= DONE;
                            res_data <= '0;
                        end else begin
                            state      <= RUN;
                            acc        <= '0;
                            beats_left <= (cmd_len >> 2) + LEN_W'(cmd_len[1:0] != 2'd0);
                            tail       <= cmd_len[1:0];
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state      <= IDLE;
                        acc        <= '0;
                        beats_left <= '0;
                    end else if (in_valid) begin
                        acc        <= acc + dp_result;
                        beats_left <= beats_left - LEN_W'(1);
                        if (last_beat) begin
                            state    <= DONE;
                            res_data <= acc + dp_result;
                        end
                    end
                end
                DONE: begin
                    if (abort) begin
                        state <= IDLE;
                        acc   <= '0;
                    end else if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
